mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-side stage directly downstream of the multicycle control unit.
- Turns its fetch, load and store requests into single transactions on a valid/ready memory bus.
- Holds the instruction register, which feeds opcode/funct3/funct7 back to the control unit, and the load data register.
- Handles byte/half/word lane steering, sign extension, misalignment detection and a bus watchdog.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles mem_valid may wait for mem_ready before a bus error; 0 disables the watchdog.

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_fetch  in  1  instruction fetch request (driven from control unit ir_write)
req_read  in  1  data load request
req_write  in  1  data store request
funct3  in  3  access size/sign for loads and stores (RV32I encoding)
addr  in  32  byte address of the access
wdata  in  32  store data, value in low bits
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
instr  out  32  instruction register
rdata  out  32  extended load data register
misaligned  out  1  last accepted request was misaligned
bus_error  out  1  last accepted request timed out
mem_valid  out  1  bus request valid
mem_instr  out  1  current bus request is a fetch
mem_ready  in  1  bus completion from memory
mem_addr  out  32  word-aligned bus address
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte write strobes; 0 for reads/fetches
mem_rdata  in  32  bus read data

Behaviour:
- Reset values:
  - state=IDLE; busy=0; done=0; rdata=0; misaligned=0; bus_error=0.
  - instr=32'h00000013 (NOP).
  - mem_valid=0; mem_instr=0; mem_addr=0; mem_wdata=0; mem_wstrb=0; watchdog counter=0.
- States:
  - IDLE: requests sampled only here.
  - BUS: mem_valid=1.
  - RESP: done=1 for exactly one cycle, then back to IDLE.
- IDLE, any request high at edge N:
  - Accept it and clear misaligned/bus_error.
  - Priority when more than one request is high: fetch > write > read.
  - Register mem_addr={addr[31:2],2'b00}, mem_wstrb, mem_wdata and mem_instr; go to BUS (mem_valid visible in cycle N+1).
  - If misaligned, set misaligned=1, go straight to RESP and issue no bus transaction.
- Misalignment rules:
  - Fetch and word access (funct3[1:0]=10): addr[1:0]!=0.
  - Halfword access (funct3[1:0]=01): addr[0]!=0.
  - Byte access: never misaligned.
  - funct3[1:0]=11: treated as a word access.
- Store strobes and data:
  - SB: mem_wstrb=4'b0001<<addr[1:0]; mem_wdata={4{wdata[7:0]}}.
  - SH: mem_wstrb=addr[1]?1100:0011; mem_wdata={2{wdata[15:0]}}.
  - SW: mem_wstrb=1111; mem_wdata=wdata.
- BUS state:
  - mem_valid, mem_addr, mem_wdata, mem_wstrb and mem_instr are held stable until mem_ready is sampled high.
  - On the ready edge: drop mem_valid, go to RESP.
  - On a fetch ready edge: instr<=mem_rdata.
  - On a load ready edge: rdata<=extended lane data.
  - Stores leave instr and rdata unchanged.
- Load extension, lane selected by addr[1:0]:
  - funct3[2]=0: sign-extend.
  - funct3[2]=1: zero-extend.
- Watchdog:
  - Counter cleared on entry to BUS and incremented each BUS cycle with mem_ready low.
  - When the count reaches TIMEOUT_CYCLES: drop mem_valid, set bus_error=1, go to RESP, leave instr/rdata unchanged.
- mem_ready is ignored in IDLE and RESP.
- Best-case latency: request at edge N, ready sampled at N+1, done high in cycle N+2, next request accepted at edge N+3.
- Reset mid-operation: state returns to IDLE on that edge, mem_valid drops, no done pulse, all registers take reset values.

Test Plan:
- Fetch:
  - Stimulus: req_fetch, addr=0x100; mem_ready asserted after 3 BUS cycles; mem_rdata=0x00500093.
  - Response: mem_valid=1, mem_instr=1, mem_addr=0x100, mem_wstrb=0 throughout; instr=0x00500093; done high exactly one cycle.
- Byte loads:
  - Stimulus: req_read, funct3=000, addr=0x203, mem_rdata=0x80FF7F01.
  - Response: rdata=0xFFFFFF80; repeating with funct3=100 gives 0x00000080.
- Halfword store:
  - Stimulus: req_write, funct3=001, addr=0x302, wdata=0x1234ABCD.
  - Response: mem_addr=0x300, mem_wstrb=1100, mem_wdata=0xABCDABCD; rdata and instr unchanged.
- Misaligned word load:
  - Stimulus: req_read, funct3=010, addr=0x106.
  - Response: mem_valid never asserted; misaligned=1; done pulses in the following cycle.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=4, req_read, mem_ready held low.
  - Response: mem_valid high for 4 cycles then low; bus_error=1; done pulses once.
  - Follow-up: the next accepted request clears bus_error.
- Reset and priority:
  - Stimulus: reset asserted during BUS.
  - Response: mem_valid=0 on the next edge, instr=0x00000013, no done pulse.
  - Stimulus: req_fetch and req_write high together.
  - Response: a fetch is issued.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Valid/ready memory bus between the memory access stage and the memory.
// The master issues one request at a time; the slave answers with a single ready beat.
interface mem_access_unit_if;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-side stage behind the multicycle control unit: turns fetch/load/store requests
// into single bus transactions and owns the instruction and load-data registers.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_fetch,
    input  logic                      req_read,
    input  logic                      req_write,
    input  logic [2:0]                funct3,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               instr,
    output logic [31:0]               rdata,
    output logic                      misaligned,
    output logic                      bus_error,
    mem_access_unit_if.master         bus
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_done;
    logic [31:0]   r_instr;
    logic [31:0]   r_rdata;
    logic          r_misaligned;
    logic          r_bus_error;
    logic          r_mem_valid;
    logic          r_mem_instr;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic          r_is_load;
    logic [2:0]    r_funct3;
    logic [1:0]    r_lane;
    logic [CW-1:0] r_cnt;

    logic          w_any_req;
    logic          w_is_fetch;
    logic          w_is_write;
    logic          w_is_load;
    logic [1:0]    w_size;
    logic          w_misaligned;
    logic [3:0]    w_wstrb;
    logic [31:0]   w_wdata;
    logic [7:0]    w_ld_byte;
    logic [15:0]   w_ld_half;
    logic [31:0]   w_ld_ext;
    logic          w_timeout;

    // Fetch beats write beats read when several requests arrive together.
    assign w_any_req  = req_fetch | req_read | req_write;
    assign w_is_fetch = req_fetch;
    assign w_is_write = ~req_fetch & req_write;
    assign w_is_load  = ~req_fetch & ~req_write & req_read;
    assign w_size     = req_fetch ? 2'b10 : funct3[1:0];

    always_comb begin
        w_misaligned = 1'b0;
        case (w_size)
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = addr[0];
            default: w_misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int HB = gi % 2;
            assign w_wstrb[gi] = w_is_write &
                ((w_size == 2'b00) ? (addr[1:0] == 2'(gi)) :
                 (w_size == 2'b01) ? (addr[1] == (gi >= 2)) : 1'b1);
            assign w_wdata[8*gi +: 8] =
                (w_size == 2'b00) ? wdata[7:0] :
                (w_size == 2'b01) ? wdata[8*HB +: 8] : wdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_ld_byte = bus.mem_rdata[7:0];
        case (r_lane)
            2'd0:    w_ld_byte = bus.mem_rdata[7:0];
            2'd1:    w_ld_byte = bus.mem_rdata[15:8];
            2'd2:    w_ld_byte = bus.mem_rdata[23:16];
            default: w_ld_byte = bus.mem_rdata[31:24];
        endcase
        w_ld_half = r_lane[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_ld_ext  = bus.mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_ld_ext = r_funct3[2] ? {24'd0, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_ext = r_funct3[2] ? {16'd0, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
            default: w_ld_ext = bus.mem_rdata;
        endcase
    end

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_done       <= 1'b0;
            r_instr      <= NOP;
            r_rdata      <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_instr  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_is_load    <= 1'b0;
            r_funct3     <= '0;
            r_lane       <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_misaligned <= w_misaligned;
                        r_bus_error  <= 1'b0;
                        if (w_misaligned) begin
                            r_state <= S_RESP;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_BUS;
                            r_mem_valid <= 1'b1;
                            r_mem_instr <= w_is_fetch;
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= w_wstrb;
                            r_is_load   <= w_is_load;
                            r_funct3    <= funct3;
                            r_lane      <= addr[1:0];
                            r_cnt       <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (bus.mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_RESP;
                        r_done      <= 1'b1;
                        if (r_mem_instr) begin
                            r_instr <= bus.mem_rdata;
                        end else if (r_is_load) begin
                            r_rdata <= w_ld_ext;
                        end
                    end else if (w_timeout) begin
                        r_mem_valid <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_state     <= S_RESP;
                        r_done      <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done      <= 1'b0;
                    r_mem_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign instr      = r_instr;
    assign rdata      = r_rdata;
    assign misaligned = r_misaligned;
    assign bus_error  = r_bus_error;

    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_instr = r_mem_instr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized requests checked against
// a byte-oriented reference model of lane steering, extension and misalignment.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_fetch, req_read, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, misaligned, bus_error;
    logic [31:0] instr, rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_fetch  (req_fetch),
        .req_read   (req_read),
        .req_write  (req_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .instr      (instr),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Loaded value from the byte view of the bus word.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int          nb;
        logic [31:0] mask;
        logic [31:0] v;
        nb   = f3[1] ? 4 : (f3[0] ? 2 : 1);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = (rd >> (8 * (a % 4))) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic run_access(input bit rf, input bit rw, input bit rr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd, input int dly,
                              input logic [31:0] rd);
        int          kind;
        int          nb;
        bit          mis;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [37:0] e_bus;
        logic [37:0] o_bus;
        kind   = rf ? 0 : (rw ? 1 : 2);
        nb     = (kind == 0 || f3[1]) ? 4 : (f3[0] ? 2 : 1);
        mis    = (a % nb) != 0;
        e_strb = (kind == 1) ? 4'(((1 << nb) - 1) << (a % 4)) : 4'b0000;
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        e_bus  = {1'b1, (kind == 0), a[31:2], 2'b00, e_strb};

        req_fetch = rf; req_write = rw; req_read = rr;
        funct3 = f3; addr = a; wdata = wd;
        step();
        req_fetch = 0; req_write = 0; req_read = 0;
        funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;

        if (mis) begin
            n_checks++;
            if ({bus.mem_valid, misaligned, bus_error, done, busy} !== 5'b01011) begin
                n_fail++;
                $display("FAIL misaligned_resp a=%h f3=%b got v/mis/err/done/busy=%b want 01011",
                         a, f3, {bus.mem_valid, misaligned, bus_error, done, busy});
            end
            step();
        end else begin
            for (int d = 0; d <= dly; d++) begin
                o_bus = {bus.mem_valid, bus.mem_instr, bus.mem_addr, bus.mem_wstrb};
                n_checks++;
                if (o_bus !== e_bus) begin
                    n_fail++;
                    $display("FAIL bus_req a=%h cyc=%0d got v/i/addr/strb=%h want %h", a, d, o_bus, e_bus);
                end
                if (kind == 1) begin
                    n_checks++;
                    if (bus.mem_wdata !== e_wd) begin
                        n_fail++;
                        $display("FAIL bus_wdata a=%h got %h want %h", a, bus.mem_wdata, e_wd);
                    end
                end
                n_checks++;
                if ({done, busy, misaligned, bus_error} !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL bus_status a=%h got done/busy/mis/err=%b want 0100",
                             a, {done, busy, misaligned, bus_error});
                end
                bus.mem_ready = (d == dly);
                bus.mem_rdata = (d == dly) ? rd : $urandom;
                step();
            end
            bus.mem_ready = 1'($urandom);
            bus.mem_rdata = $urandom;
            if (kind == 0) exp_instr = rd;
            if (kind == 2) exp_rdata = model_load(f3, a, rd);
            n_checks++;
            if ({bus.mem_valid, done, busy} !== 3'b011 || instr !== exp_instr || rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL resp a=%h kind=%0d got v/done/busy=%b instr=%h rdata=%h want 011 %h %h",
                         a, kind, {bus.mem_valid, done, busy}, instr, rdata, exp_instr, exp_rdata);
            end
            step();
        end
        n_checks++;
        if ({done, busy, bus.mem_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after a=%h got done/busy/valid=%b want 000", a, {done, busy, bus.mem_valid});
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({busy, done, misaligned, bus_error, bus.mem_valid, bus.mem_instr} !== 6'b0 ||
            instr !== 32'h0000_0013 || rdata !== 32'd0 || bus.mem_addr !== 32'd0 ||
            bus.mem_wdata !== 32'd0 || bus.mem_wstrb !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state flags=%b instr=%h rdata=%h addr=%h wdata=%h strb=%b",
                     {busy, done, misaligned, bus_error, bus.mem_valid, bus.mem_instr},
                     instr, rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        step();
        n_checks++;
        if ({busy, done, bus.mem_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ignores_ready got busy/done/valid=%b want 000", {busy, done, bus.mem_valid});
        end
        bus.mem_ready = 1'b0;
        exp_instr = 32'h0000_0013;
        exp_rdata = 32'd0;
    endtask

    task automatic test_fetch();
        run_access(1, 0, 0, 3'b000, 32'h0000_0100, 32'd0, 2, 32'h0050_0093);
        n_checks++;
        if (instr !== 32'h0050_0093) begin
            n_fail++;
            $display("FAIL fetch_instr got %h want 00500093", instr);
        end
    endtask

    task automatic test_byte_loads();
        run_access(0, 0, 1, 3'b000, 32'h0000_0203, 32'd0, 0, 32'h80FF_7F01);
        n_checks++;
        if (rdata !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL lb_sign got %h want ffffff80", rdata);
        end
        run_access(0, 0, 1, 3'b100, 32'h0000_0203, 32'd0, 1, 32'h80FF_7F01);
        n_checks++;
        if (rdata !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL lbu_zero got %h want 00000080", rdata);
        end
    endtask

    task automatic test_half_store();
        logic [31:0] old_i;
        logic [31:0] old_r;
        old_i = instr;
        old_r = rdata;
        req_write = 1; funct3 = 3'b001; addr = 32'h0000_0302; wdata = 32'h1234_ABCD;
        step();
        req_write = 0;
        n_checks++;
        if (bus.mem_addr !== 32'h0000_0300 || bus.mem_wstrb !== 4'b1100 || bus.mem_wdata !== 32'hABCD_ABCD) begin
            n_fail++;
            $display("FAIL sh_bus got addr=%h strb=%b wdata=%h want 00000300 1100 abcdabcd",
                     bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
        end
        bus.mem_ready = 1; bus.mem_rdata = 32'hDEAD_BEEF;
        step();
        bus.mem_ready = 0;
        step();
        n_checks++;
        if (instr !== old_i || rdata !== old_r) begin
            n_fail++;
            $display("FAIL sh_no_update got instr=%h rdata=%h want %h %h", instr, rdata, old_i, old_r);
        end
        run_access(0, 1, 0, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 1, 32'h0);
    endtask

    task automatic test_misaligned();
        run_access(0, 0, 1, 3'b010, 32'h0000_0106, 32'd0, 0, 32'd0);
        n_checks++;
        if (misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_sticky got %b want 1", misaligned);
        end
    endtask

    task automatic test_watchdog();
        req_read = 1; funct3 = 3'b010; addr = 32'h0000_0040;
        step();
        req_read = 0;
        bus.mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.mem_valid !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL wd_wait cyc=%0d got valid=%b done=%b want 1 0", i, bus.mem_valid, done);
            end
            step();
        end
        n_checks++;
        if ({bus.mem_valid, bus_error, done} !== 3'b011 || instr !== exp_instr || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL wd_expire got valid/err/done=%b instr=%h rdata=%h want 011 %h %h",
                     {bus.mem_valid, bus_error, done}, instr, rdata, exp_instr, exp_rdata);
        end
        step();
        n_checks++;
        if ({done, busy, bus_error} !== 3'b001) begin
            n_fail++;
            $display("FAIL wd_after got done/busy/err=%b want 001", {done, busy, bus_error});
        end
        run_access(1, 0, 0, 3'b000, 32'h0000_0044, 32'd0, 0, 32'h0010_0113);
        n_checks++;
        if (bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_clear got %b want 0", bus_error);
        end
    endtask

    task automatic test_reset_mid();
        req_fetch = 1; addr = 32'h0000_0700;
        step();
        req_fetch = 0;
        n_checks++;
        if (bus.mem_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre got valid=%b want 1", bus.mem_valid);
        end
        reset = 1;
        step();
        reset = 0;
        exp_instr = 32'h0000_0013;
        exp_rdata = 32'd0;
        n_checks++;
        if ({bus.mem_valid, busy, done} !== 3'b000 || instr !== 32'h0000_0013 || rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid got valid/busy/done=%b instr=%h rdata=%h want 000 00000013 0",
                     {bus.mem_valid, busy, done}, instr, rdata);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid_nodone cyc=%0d got done=%b want 0", i, done);
            end
            step();
        end
    endtask

    task automatic test_priority();
        run_access(1, 1, 0, 3'b010, 32'h0000_0500, 32'h5555_AAAA, 0, 32'h0000_0073);
        run_access(0, 1, 1, 3'b000, 32'h0000_0501, 32'h0000_00C3, 0, 32'h0);
        n_checks++;
        if (instr !== 32'h0000_0073) begin
            n_fail++;
            $display("FAIL priority_fetch got instr=%h want 00000073", instr);
        end
    endtask

    task automatic test_random();
        logic [2:0] rq;
        for (int n = 0; n < 60; n++) begin
            rq = 3'($urandom_range(1, 7));
            run_access(rq[2], rq[1], rq[0], 3'($urandom), $urandom, $urandom,
                       $urandom_range(0, 2), $urandom);
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    initial begin
        reset = 1; req_fetch = 0; req_read = 0; req_write = 0;
        funct3 = 0; addr = 0; wdata = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        exp_instr = 32'h0000_0013;
        exp_rdata = 32'd0;
        test_reset();
        test_fetch();
        test_byte_loads();
        test_half_store();
        test_misaligned();
        test_watchdog();
        test_reset_mid();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
